// File: rtl/button_event_scheduler.sv
// Round-robin collector of button rising edges into an event FIFO, exposed as an Avalon-MM slave with a level IRQ.
// Optional per-event timestamps are compiled in with BUTTON_EVT_TIMESTAMP_EN.
module button_event_scheduler #(
  parameter int NUMBER_OF_INPUTS = 4,
  parameter int FIFO_DEPTH       = 8,
  parameter int FIFO_AW          = 3,
  parameter int TS_WIDTH         = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUMBER_OF_INPUTS-1:0] event_in,
  input  logic [1:0]                  avs_address,
  input  logic                        avs_read,
  input  logic                        avs_write,
  input  logic [31:0]                 avs_writedata,
  output logic [31:0]                 avs_readdata,
  output logic                        irq
);
  localparam int N  = NUMBER_OF_INPUTS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [N-1:0]       event_prev, pending, lost, rise, grant_oh, clr_mask;
  logic [IW-1:0]      rr_ptr, grant_idx;
  logic [IW:0]        cand;
  logic               grant_v, full, empty, push, pop, wr_en, irq_en;
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count;
  logic [IW-1:0]      idx_mem [FIFO_DEPTH];
  logic [15:0]        ts_head;
  logic [31:0]        rd_next, cnt32;
  logic [7:0]         lost8;
  logic               unused_bits;

  assign rise  = event_in & ~event_prev;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign wr_en = avs_write & ~avs_read;
  assign pop   = avs_read && (avs_address == 2'd0) && !empty;
  assign push  = grant_v;
  assign clr_mask = (wr_en && avs_address == 2'd1) ? avs_writedata[N+7:8] : '0;
  assign grant_oh = grant_v ? (N'(1) << grant_idx) : '0;

  // First pending input at or after rr_ptr, wrapping; nothing is granted while the FIFO is full.
  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!grant_v && !full && pending[cand[IW-1:0]]) begin
        grant_v   = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
  end

`ifdef BUTTON_EVT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] ts_mem [FIFO_DEPTH];
  always_ff @(posedge clk) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (push) ts_mem[wptr] <= ts_cnt;
  end
  assign ts_head     = 16'(ts_mem[rptr]);
  assign unused_bits = ^avs_writedata;
`else
  assign ts_head     = '0;
  assign unused_bits = ^{avs_writedata, 16'(TS_WIDTH)};
`endif

  always_comb begin
    lost8        = '0;
    lost8[N-1:0] = lost;
    cnt32        = 32'(count);
    rd_next      = '0;
    case (avs_address)
      2'd0: if (!empty) begin
        rd_next[31]     = 1'b1;
        rd_next[23:8]   = ts_head;
        rd_next[IW-1:0] = idx_mem[rptr];
      end
      2'd1: begin
        rd_next[7:0]  = cnt32[7:0];
        rd_next[15:8] = lost8;
        rd_next[16]   = full;
      end
      2'd2:    rd_next[0] = irq_en;
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) idx_mem[wptr] <= grant_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      event_prev   <= '0;
      pending      <= '0;
      lost         <= '0;
      rr_ptr       <= '0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      irq_en       <= 1'b0;
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      event_prev <= event_in;
      // A fresh edge on the granted input re-arms pending rather than counting as lost.
      pending    <= (pending & ~grant_oh) | rise;
      lost       <= (lost & ~clr_mask) | (rise & pending & ~grant_oh);
      if (grant_v) rr_ptr <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + IW'(1);
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && avs_address == 2'd2) irq_en <= avs_writedata[0];
      if (avs_read) avs_readdata <= rd_next;
      irq <= irq_en & (count != '0);
    end
  end
endmodule

// File: tb/tb_button_event_scheduler.sv
// Bench for button_event_scheduler: a queue-based event model checked every cycle, plus directed literal checks.
module tb_button_event_scheduler;
  localparam int N = 4;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  event_in = '0;
  logic [1:0]  addr = '0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  int errs = 0, checks = 0;

  button_event_scheduler #(.NUMBER_OF_INPUTS(N), .FIFO_DEPTH(D), .FIFO_AW(3), .TS_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .event_in(event_in), .avs_address(addr), .avs_read(rd),
    .avs_write(wr), .avs_writedata(wdata), .avs_readdata(rdata), .irq(irq));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO as queues, pending/lost as bit sets, arbitration by scanning from the rr index.
  int          q_idx[$];
  int          q_ts[$];
  bit [3:0]    mp, ml, mprev;
  int          mrr, mts;
  bit          men, mirq;
  logic [31:0] mrd;

  always @(posedge clk) begin
    int oldsize, g, j;
    bit [3:0] r, goh, clr;
    if (reset) begin
      q_idx.delete(); q_ts.delete();
      mp = 0; ml = 0; mprev = 0; mrr = 0; mts = 0; men = 0; mirq = 0; mrd = 0;
    end else begin
      r = event_in & ~mprev;
      oldsize = q_idx.size();
      mirq = men && (oldsize != 0);
      if (rd) begin
        case (addr)
          2'd0: if (oldsize > 0) begin
            mrd = 32'h8000_0000 | (32'(q_ts[0]) << 8) | 32'(q_idx[0]);
            void'(q_idx.pop_front()); void'(q_ts.pop_front());
          end else mrd = 0;
          2'd1: mrd = 32'(oldsize) | (32'(ml) << 8) | ((oldsize == D) ? 32'h1_0000 : 32'h0);
          2'd2: mrd = 32'(men);
          default: mrd = 0;
        endcase
      end
      g = -1;
      if (oldsize < D)
        for (int k = 0; k < N; k++) begin
          j = (mrr + k) % N;
          if (g < 0 && mp[j]) g = j;
        end
      goh = 0;
      if (g >= 0) begin
        goh[g] = 1'b1;
        q_idx.push_back(g); q_ts.push_back(mts);
        mrr = (g + 1) % N;
      end
      clr = 0;
      if (wr && !rd) begin
        if (addr == 2'd1) clr = wdata[11:8];
        if (addr == 2'd2) men = wdata[0];
      end
      ml = (ml & ~clr) | (r & mp & ~goh);
      mp = (mp & ~goh) | r;
`ifdef BUTTON_EVT_TIMESTAMP_EN
      mts = (mts + 1) % 65536;
`endif
      mprev = event_in;
    end
    #1;
    chk("irq", 32'(irq), 32'(mirq));
    chk("readdata", rdata, mrd);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0; d = rdata;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] v);
    addr = a; wdata = v; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] bits, input int width);
    event_in = bits;
    tick(width);
    event_in = '0;
  endtask

  initial begin
    logic [31:0] d, d2;
    tick(3);
    chk("reset_readdata", rdata, 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    tick(1);

    // Empty reads
    rd_reg(2'd0, d); chk("empty_event", d, 32'h0);
    rd_reg(2'd1, d); chk("empty_status", d, 32'h0);
    chk("idle_irq", 32'(irq), 32'h0);

    // irq enable, and read+write in one cycle leaves irq_en alone
    wr_reg(2'd2, 32'h1);
    addr = 2'd2; wdata = 32'h0; rd = 1'b1; wr = 1'b1;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0; d = rdata;
    chk("rw_ctrl_read", d, 32'h1);
    rd_reg(2'd2, d); chk("ctrl_kept", d, 32'h1);

    // Single 4-clock pulse on input 2
    event_in = 4'b0100;
    tick(2); chk("irq_t2", 32'(irq), 32'h0);
    tick(1); chk("irq_t3", 32'(irq), 32'h1);
    tick(1); event_in = '0;
    rd_reg(2'd1, d); chk("status_cnt1", d, 32'h1);
    rd_reg(2'd0, d); chk("event_in2", d & 32'hFF0000FF, 32'h8000_0002);
`ifndef BUTTON_EVT_TIMESTAMP_EN
    chk("ts_zero", 32'(d[23:8]), 32'h0);
`endif
    tick(2);
    chk("irq_drop", 32'(irq), 32'h0);
    rd_reg(2'd1, d); chk("status_cnt0", d, 32'h0);

    // Bring rr to 0 via input 3, then round-robin order with wrap
    pulse(4'b1000, 1); tick(4);
    rd_reg(2'd0, d); chk("rr_seed", d & 32'hFF0000FF, 32'h8000_0003);
    pulse(4'b1011, 1); tick(6);
    rd_reg(2'd0, d); chk("rr_a0", d & 32'hFF0000FF, 32'h8000_0000);
    rd_reg(2'd0, d); chk("rr_a1", d & 32'hFF0000FF, 32'h8000_0001);
    rd_reg(2'd0, d); chk("rr_a3", d & 32'hFF0000FF, 32'h8000_0003);
    pulse(4'b1001, 1); tick(5);
    rd_reg(2'd0, d); chk("rr_wrap0", d & 32'hFF0000FF, 32'h8000_0000);
    rd_reg(2'd0, d); chk("rr_wrap3", d & 32'hFF0000FF, 32'h8000_0003);

    // Fill, overflow on input 1, pop frees a slot, W1C lost
    pulse(4'b1111, 1); tick(6);
    pulse(4'b1111, 1); tick(6);
    pulse(4'b0010, 1); tick(1);
    pulse(4'b0010, 1); tick(2);
    rd_reg(2'd1, d); chk("full_lost", d, 32'h0001_0208);
    rd_reg(2'd0, d); chk("full_pop", d & 32'hFF0000FF, 32'h8000_0000);
    tick(3);
    rd_reg(2'd1, d); chk("refill", d, 32'h0001_0208);
    wr_reg(2'd1, 32'h200);
    rd_reg(2'd1, d); chk("lost_clr", d, 32'h0001_0008);

    // Drain, then pop and grant coincide at count 3
    repeat (8) rd_reg(2'd0, d);
    rd_reg(2'd1, d); chk("drained", d, 32'h0);
    pulse(4'b0111, 1); tick(5);
    event_in = 4'b1000;
    @(negedge clk);
    event_in = '0; addr = 2'd0; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0; d = rdata;
    chk("popgrant_head", d & 32'hFF0000FF, 32'h8000_0002);
    rd_reg(2'd1, d); chk("popgrant_cnt", d, 32'h3);

    // Reset mid-burst
    event_in = 4'b1111; tick(1);
    event_in = '0; tick(1);
    reset = 1'b1; tick(1);
    reset = 1'b0; tick(1);
    rd_reg(2'd0, d); chk("rst_event", d, 32'h0);
    rd_reg(2'd1, d); chk("rst_status", d, 32'h0);
    rd_reg(2'd2, d); chk("rst_ctrl", d, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

`ifdef BUTTON_EVT_TIMESTAMP_EN
    pulse(4'b0001, 1); tick(99);
    pulse(4'b0001, 1); tick(4);
    rd_reg(2'd0, d);
    rd_reg(2'd0, d2);
    chk("ts_delta", 32'(16'(d2[23:8] - d[23:8])), 32'd100);
`endif

    tick(2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
